// File: rtl/execute_result_queue_pkg.sv
// Shared types for the execute result queue: payload bundle and redirect classification.
package execute_result_queue_pkg;

  localparam int unsigned XlenDef  = 32;
  localparam int unsigned FlenDef  = 64;
  localparam int unsigned IlenDef  = 32;
  localparam int unsigned OpWDef   = 32;
  localparam int unsigned TrapWDef = 40;

  localparam int unsigned TRAP_VALID_BIT = 0;

  typedef struct packed {
    logic [XlenDef-1:0]  pc;
    logic [IlenDef-1:0]  insn;
    logic [OpWDef-1:0]   op;
    logic [XlenDef-1:0]  int_value;
    logic [FlenDef-1:0]  fp_value;
    logic                branch_taken;
    logic [XlenDef-1:0]  branch_target;
    logic [TrapWDef-1:0] trap_info;
    logic                trap_return;
  } exec_result_t;

  function automatic logic is_redirect(exec_result_t r);
    return r.branch_taken | r.trap_info[TRAP_VALID_BIT] | r.trap_return;
  endfunction

endpackage

// File: rtl/execute_queue_ptr.sv
// Read/write pointer pair with one extra wrap bit; derives full, empty and occupancy.
module execute_queue_ptr #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            i_clear,
  input  logic            i_push,
  input  logic            i_pop,
  output logic [PtrW-2:0] o_wr_idx,
  output logic [PtrW-2:0] o_rd_idx,
  output logic            o_full,
  output logic            o_empty,
  output logic [PtrW-1:0] o_count
);

  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_wr_idx = r_wr_ptr[PtrW-2:0];
  assign o_rd_idx = r_rd_ptr[PtrW-2:0];
  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_full   = (r_wr_ptr[PtrW-1] != r_rd_ptr[PtrW-1]) &&
                    (r_wr_ptr[PtrW-2:0] == r_rd_ptr[PtrW-2:0]);
  // Modulo-2*DEPTH difference is the occupancy directly.
  assign o_count  = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/execute_result_queue.sv
// FIFO of execute results between execute and memory/writeback, with redirect pulse on retire
// of a branch-taken / trap / xRET entry and input kill while such an entry is in flight.
module execute_result_queue
  import execute_result_queue_pkg::*;
#(
  parameter int unsigned XLEN   = XlenDef,
  parameter int unsigned FLEN   = FlenDef,
  parameter int unsigned ILEN   = IlenDef,
  parameter int unsigned OP_W   = OpWDef,
  parameter int unsigned TRAP_W = TrapWDef,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   flush,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [XLEN-1:0]        inPc,
  input  logic [ILEN-1:0]        inInsn,
  input  logic [OP_W-1:0]        inOp,
  input  logic [XLEN-1:0]        inIntValue,
  input  logic [FLEN-1:0]        inFpValue,
  input  logic                   inBranchTaken,
  input  logic [XLEN-1:0]        inBranchTarget,
  input  logic [TRAP_W-1:0]      inTrapInfo,
  input  logic                   inTrapReturn,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [XLEN-1:0]        outPc,
  output logic [ILEN-1:0]        outInsn,
  output logic [OP_W-1:0]        outOp,
  output logic [XLEN-1:0]        outIntValue,
  output logic [FLEN-1:0]        outFpValue,
  output logic                   outBranchTaken,
  output logic [XLEN-1:0]        outBranchTarget,
  output logic [TRAP_W-1:0]      outTrapInfo,
  output logic                   outTrapReturn,
  output logic                   redirectValid,
  output logic [XLEN-1:0]        redirectTarget,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  exec_result_t r_entry [DEPTH];
  exec_result_t w_in;
  exec_result_t w_head;

  logic [IdxW-1:0] w_wr_idx;
  logic [IdxW-1:0] w_rd_idx;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_redirect_fire;
  logic            w_pending_d;
  logic            r_redirect_pending;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_target;

  assign w_in.pc            = inPc;
  assign w_in.insn          = inInsn;
  assign w_in.op            = inOp;
  assign w_in.int_value     = inIntValue;
  assign w_in.fp_value      = inFpValue;
  assign w_in.branch_taken  = inBranchTaken;
  assign w_in.branch_target = inBranchTarget;
  assign w_in.trap_info     = inTrapInfo;
  assign w_in.trap_return   = inTrapReturn;

  assign inReady  = !w_full && !r_redirect_pending;
  assign outValid = !w_empty;
  assign w_push   = inValid && inReady && !flush;
  assign w_pop    = outValid && outReady && !flush;

  execute_queue_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk      (clk),
    .rstN     (rstN),
    .i_clear  (flush),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .o_wr_idx (w_wr_idx),
    .o_rd_idx (w_rd_idx),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (count)
  );

  always_ff @(posedge clk) begin
    if (w_push) r_entry[w_wr_idx] <= w_in;
  end

  assign w_head          = r_entry[w_rd_idx];
  assign outPc           = w_head.pc;
  assign outInsn         = w_head.insn;
  assign outOp           = w_head.op;
  assign outIntValue     = w_head.int_value;
  assign outFpValue      = w_head.fp_value;
  assign outBranchTaken  = w_head.branch_taken;
  assign outBranchTarget = w_head.branch_target;
  assign outTrapInfo     = w_head.trap_info;
  assign outTrapReturn   = w_head.trap_return;

  assign w_redirect_fire = w_pop && is_redirect(w_head);

  // A redirecting entry is always the youngest in the queue, so its dequeue ends the kill window.
  always_comb begin
    w_pending_d = r_redirect_pending;
    if (flush) begin
      w_pending_d = 1'b0;
    end else if (w_push && is_redirect(w_in)) begin
      w_pending_d = 1'b1;
    end else if (w_redirect_fire) begin
      w_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_redirect_pending <= 1'b0;
      r_redirect_valid   <= 1'b0;
      r_redirect_target  <= '0;
    end else begin
      r_redirect_pending <= w_pending_d;
      r_redirect_valid   <= w_redirect_fire;
      // Traps and xRET report 0; the CSR unit supplies the real vector.
      if (w_redirect_fire && w_head.branch_taken && !w_head.trap_info[TRAP_VALID_BIT] &&
          !w_head.trap_return) begin
        r_redirect_target <= w_head.branch_target;
      end else begin
        r_redirect_target <= '0;
      end
    end
  end

  assign redirectValid  = r_redirect_valid;
  assign redirectTarget = r_redirect_target;

endmodule

// File: tb/tb_execute_result_queue.sv
// Directed bench: DEPTH=2 and DEPTH=4 instances driven by shared stimulus.
module tb_execute_result_queue;

  logic        clk = 1'b0;
  logic        rstN;
  logic        flush;
  logic        inValid;
  logic [31:0] inPc;
  logic [31:0] inInsn;
  logic [31:0] inOp;
  logic [31:0] inIntValue;
  logic [63:0] inFpValue;
  logic        inBranchTaken;
  logic [31:0] inBranchTarget;
  logic [39:0] inTrapInfo;
  logic        inTrapReturn;
  logic        outReady;

  logic        a_inReady, a_outValid, a_outBranchTaken, a_outTrapReturn, a_redirectValid;
  logic [31:0] a_outPc, a_outInsn, a_outOp, a_outIntValue, a_outBranchTarget, a_redirectTarget;
  logic [63:0] a_outFpValue;
  logic [39:0] a_outTrapInfo;
  logic [1:0]  a_count;

  logic        b_inReady, b_outValid, b_outBranchTaken, b_outTrapReturn, b_redirectValid;
  logic [31:0] b_outPc, b_outInsn, b_outOp, b_outIntValue, b_outBranchTarget, b_redirectTarget;
  logic [63:0] b_outFpValue;
  logic [39:0] b_outTrapInfo;
  logic [2:0]  b_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  execute_result_queue #(.DEPTH(2)) u_d2 (
    .clk(clk), .rstN(rstN), .flush(flush), .inValid(inValid), .inReady(a_inReady),
    .inPc(inPc), .inInsn(inInsn), .inOp(inOp), .inIntValue(inIntValue), .inFpValue(inFpValue),
    .inBranchTaken(inBranchTaken), .inBranchTarget(inBranchTarget), .inTrapInfo(inTrapInfo),
    .inTrapReturn(inTrapReturn), .outValid(a_outValid), .outReady(outReady), .outPc(a_outPc),
    .outInsn(a_outInsn), .outOp(a_outOp), .outIntValue(a_outIntValue),
    .outFpValue(a_outFpValue), .outBranchTaken(a_outBranchTaken),
    .outBranchTarget(a_outBranchTarget), .outTrapInfo(a_outTrapInfo),
    .outTrapReturn(a_outTrapReturn), .redirectValid(a_redirectValid),
    .redirectTarget(a_redirectTarget), .count(a_count)
  );

  execute_result_queue #(.DEPTH(4)) u_d4 (
    .clk(clk), .rstN(rstN), .flush(flush), .inValid(inValid), .inReady(b_inReady),
    .inPc(inPc), .inInsn(inInsn), .inOp(inOp), .inIntValue(inIntValue), .inFpValue(inFpValue),
    .inBranchTaken(inBranchTaken), .inBranchTarget(inBranchTarget), .inTrapInfo(inTrapInfo),
    .inTrapReturn(inTrapReturn), .outValid(b_outValid), .outReady(outReady), .outPc(b_outPc),
    .outInsn(b_outInsn), .outOp(b_outOp), .outIntValue(b_outIntValue),
    .outFpValue(b_outFpValue), .outBranchTaken(b_outBranchTaken),
    .outBranchTarget(b_outBranchTarget), .outTrapInfo(b_outTrapInfo),
    .outTrapReturn(b_outTrapReturn), .redirectValid(b_redirectValid),
    .redirectTarget(b_redirectTarget), .count(b_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    inPc = '0; inInsn = 32'h0000_0013; inOp = '0; inIntValue = '0; inFpValue = '0;
    inBranchTaken = 1'b0; inBranchTarget = '0; inTrapInfo = '0; inTrapReturn = 1'b0;
    #12;
    check("rst_outValid", {63'd0, a_outValid}, 64'd0);
    check("rst_count", {62'd0, a_count}, 64'd0);
    check("rst_inReady", {63'd0, a_inReady}, 64'd1);
    check("rst_redirectValid", {63'd0, a_redirectValid}, 64'd0);
    check("rst_redirectTarget", {32'd0, a_redirectTarget}, 64'd0);
    rstN = 1'b1;
    step();

    // Fill/drain on DEPTH=2
    inValid = 1'b1; inPc = 32'h100;
    step();
    check("fill_count1", {62'd0, a_count}, 64'd1);
    check("fill_outValid", {63'd0, a_outValid}, 64'd1);
    inPc = 32'h104;
    step();
    check("fill_count2", {62'd0, a_count}, 64'd2);
    check("fill_inReady_full", {63'd0, a_inReady}, 64'd0);
    inPc = 32'h108;
    step();
    check("fill_third_ignored", {62'd0, a_count}, 64'd2);
    inValid = 1'b0; outReady = 1'b1;
    check("drain_head0", {32'd0, a_outPc}, 64'h100);
    step();
    check("drain_count1", {62'd0, a_count}, 64'd1);
    check("drain_head1", {32'd0, a_outPc}, 64'h104);
    step();
    check("drain_count0", {62'd0, a_count}, 64'd0);
    check("drain_empty", {63'd0, a_outValid}, 64'd0);

    // Reset mid-traffic, checked between edges
    outReady = 1'b0; inValid = 1'b1; inPc = 32'h110;
    step();
    inPc = 32'h114;
    step();
    inValid = 1'b0;
    check("mid_count_before", {62'd0, a_count}, 64'd2);
    #3 rstN = 1'b0;
    #1;
    check("mid_rst_outValid", {63'd0, a_outValid}, 64'd0);
    check("mid_rst_count", {62'd0, a_count}, 64'd0);
    check("mid_rst_inReady", {63'd0, a_inReady}, 64'd1);
    #2 rstN = 1'b1;
    step();

    // Wrap on DEPTH=4: enqueue and dequeue every cycle
    inValid = 1'b1; outReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      inPc = 32'h200 + 32'(4 * i);
      step();
      check($sformatf("wrap_count_%0d", i), {61'd0, b_count}, 64'd1);
      check($sformatf("wrap_pc_%0d", i), {32'd0, b_outPc}, 64'h200 + 64'(4 * i));
    end
    inValid = 1'b0;
    step();
    check("wrap_drained", {61'd0, b_count}, 64'd0);

    // Branch redirect and input kill
    outReady = 1'b0; inValid = 1'b1; inPc = 32'h2f0;
    inBranchTaken = 1'b1; inBranchTarget = 32'h8000_0040;
    step();
    check("br_kill_inReady", {63'd0, a_inReady}, 64'd0);
    inPc = 32'h300; inBranchTaken = 1'b0; inBranchTarget = '0;
    step();
    check("br_0x300_refused", {62'd0, a_count}, 64'd1);
    check("br_head_target", {32'd0, a_outBranchTarget}, 64'h8000_0040);
    inValid = 1'b0; outReady = 1'b1;
    check("br_no_early_pulse", {63'd0, a_redirectValid}, 64'd0);
    step();
    check("br_redirectValid", {63'd0, a_redirectValid}, 64'd1);
    check("br_redirectTarget", {32'd0, a_redirectTarget}, 64'h8000_0040);
    outReady = 1'b0;
    step();
    check("br_pulse_one_cycle", {63'd0, a_redirectValid}, 64'd0);
    check("br_inReady_restored", {63'd0, a_inReady}, 64'd1);

    // Trap beats branch
    inValid = 1'b1; inPc = 32'h320; inTrapInfo = 40'h1;
    inBranchTaken = 1'b1; inBranchTarget = 32'h44;
    step();
    inValid = 1'b0; inTrapInfo = '0; inBranchTaken = 1'b0; inBranchTarget = '0;
    outReady = 1'b1;
    step();
    check("trap_redirectValid", {63'd0, a_redirectValid}, 64'd1);
    check("trap_redirectTarget", {32'd0, a_redirectTarget}, 64'd0);
    outReady = 1'b0;
    step();

    // Flush with three entries and concurrent enqueue+dequeue (DEPTH=4)
    inValid = 1'b1;
    inPc = 32'h400; step();
    inPc = 32'h404; step();
    inPc = 32'h408; step();
    check("fl_count3", {61'd0, b_count}, 64'd3);
    flush = 1'b1; outReady = 1'b1; inPc = 32'h40c;
    step();
    flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    check("fl_count0", {61'd0, b_count}, 64'd0);
    check("fl_outValid", {63'd0, b_outValid}, 64'd0);
    check("fl_redirectValid", {63'd0, b_redirectValid}, 64'd0);
    check("fl_inReady", {63'd0, b_inReady}, 64'd1);

    // Flush coinciding with dequeue of a redirecting head
    inValid = 1'b1; inPc = 32'h500; inBranchTaken = 1'b1; inBranchTarget = 32'h600;
    step();
    inBranchTaken = 1'b0; inBranchTarget = '0; inPc = 32'h504;
    flush = 1'b1; outReady = 1'b1;
    step();
    flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    check("flr_redirectValid", {63'd0, a_redirectValid}, 64'd0);
    check("flr_count", {62'd0, a_count}, 64'd0);
    check("flr_inReady", {63'd0, a_inReady}, 64'd1);
    step();
    check("flr_no_late_pulse", {63'd0, a_redirectValid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
